// File: rtl/pwm_compare_deadtime_pkg.sv
// Shared widths and FSM encoding for the compare/deadtime PWM stage.
// Deadtime insertion is compiled in only when PWM_COMPARE_DEADTIME_EN is defined.
package pwm_compare_pkg;

  localparam int COUNTER_WIDTH_DEF  = 16;
  localparam int DEADTIME_WIDTH_DEF = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HIGH_ON = 3'd1;
  localparam logic [2:0] ST_DT_HL   = 3'd2;
  localparam logic [2:0] ST_LOW_ON  = 3'd3;
  localparam logic [2:0] ST_DT_LH   = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    HIGH_ON = ST_HIGH_ON,
    DT_HL   = ST_DT_HL,
    LOW_ON  = ST_LOW_ON,
    DT_LH   = ST_DT_LH
  } state_e;

endpackage

// File: rtl/pwm_compare_deadtime_if.sv
// Bus between the PWM timebase/control side (master) and the compare/deadtime stage (slave).
// Honours the PWM_COMPARE_DEADTIME_EN build option only through the stage itself.
interface pwm_compare_deadtime_if
  import pwm_compare_pkg::*;
#(
  parameter int COUNTER_WIDTH  = COUNTER_WIDTH_DEF,
  parameter int DEADTIME_WIDTH = DEADTIME_WIDTH_DEF
);

  logic                      enable;
  logic [COUNTER_WIDTH-1:0]  count_in;
  logic                      load_strobe;
  logic [COUNTER_WIDTH-1:0]  compare_low_in;
  logic [COUNTER_WIDTH-1:0]  compare_high_in;
  logic [DEADTIME_WIDTH-1:0] deadtime_in;
  logic                      pwm_high;
  logic                      pwm_low;
  logic                      load_done;

  modport master (
    output enable, count_in, load_strobe, compare_low_in, compare_high_in, deadtime_in,
    input  pwm_high, pwm_low, load_done
  );

  modport slave (
    input  enable, count_in, load_strobe, compare_low_in, compare_high_in, deadtime_in,
    output pwm_high, pwm_low, load_done
  );

endinterface

// File: rtl/pwm_compare_deadtime_counter.sv
// Loadable down-counter used to time the deadtime interval; saturates at zero.
// Only instantiated when PWM_COMPARE_DEADTIME_EN is defined.
module deadtime_counter
  import pwm_compare_pkg::*;
#(
  parameter int WIDTH = DEADTIME_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pwm_compare_deadtime.sv
// Window comparator with shadowed thresholds driving complementary gate outputs.
// Define PWM_COMPARE_DEADTIME_EN to insert deadtime between the two gate drives.
module pwm_compare_deadtime
  import pwm_compare_pkg::*;
#(
  parameter int COUNTER_WIDTH  = COUNTER_WIDTH_DEF,
  parameter int DEADTIME_WIDTH = DEADTIME_WIDTH_DEF
) (
  input logic                   clockIn,
  input logic                   reset,
  pwm_compare_deadtime_if.slave bus
);

  logic [COUNTER_WIDTH-1:0] cmp_low_q, cmp_low_d;
  logic [COUNTER_WIDTH-1:0] cmp_high_q, cmp_high_d;
  logic                     load_pend_q, load_pend_d;
  logic                     load_done_q, load_done_d;
  logic                     pwm_high_q, pwm_high_d;
  logic                     pwm_low_q, pwm_low_d;
  logic                     transfer;
  logic                     raw;

  // Shadow transfer only at the counter wrap; a strobe in that same cycle stays pending.
  always_comb begin
    transfer    = bus.enable && load_pend_q && (bus.count_in == '0);
    load_pend_d = (load_pend_q && !transfer) || bus.load_strobe;
    load_done_d = transfer;
    cmp_low_d   = transfer ? bus.compare_low_in  : cmp_low_q;
    cmp_high_d  = transfer ? bus.compare_high_in : cmp_high_q;
    raw         = (bus.count_in >= cmp_low_q) && (bus.count_in < cmp_high_q);
  end

`ifdef PWM_COMPARE_DEADTIME_EN
  logic [DEADTIME_WIDTH-1:0] dt_q, dt_d;
  logic [DEADTIME_WIDTH-1:0] dt_reload;
  logic                      dt_load;
  logic                      dt_zero;
  state_e                    state_q, state_d;

  // Reload with deadtime-1 so each deadtime state lasts exactly 'deadtime' cycles.
  assign dt_reload = dt_q - 1'b1;

  deadtime_counter #(.WIDTH(DEADTIME_WIDTH)) u_deadtime_counter (
    .clk   (clockIn),
    .rst   (reset),
    .load  (dt_load),
    .value (dt_reload),
    .zero  (dt_zero)
  );

  always_comb begin
    dt_d    = transfer ? bus.deadtime_in : dt_q;
    dt_load = 1'b0;
    state_d = state_q;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = raw ? HIGH_ON : LOW_ON;
        HIGH_ON: if (!raw) begin
                   if (dt_q == '0) begin
                     state_d = LOW_ON;
                   end else begin
                     state_d = DT_HL;
                     dt_load = 1'b1;
                   end
                 end
        LOW_ON:  if (raw) begin
                   if (dt_q == '0) begin
                     state_d = HIGH_ON;
                   end else begin
                     state_d = DT_LH;
                     dt_load = 1'b1;
                   end
                 end
        DT_HL:   if (raw) state_d = HIGH_ON; else if (dt_zero) state_d = LOW_ON;
        DT_LH:   if (!raw) state_d = LOW_ON; else if (dt_zero) state_d = HIGH_ON;
        default: state_d = IDLE;
      endcase
    end
    pwm_high_d = (state_d == HIGH_ON);
    pwm_low_d  = (state_d == LOW_ON);
  end

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dt_q    <= '0;
    end else begin
      state_q <= state_d;
      dt_q    <= dt_d;
    end
  end
`else
  logic unused_deadtime;

  assign unused_deadtime = ^bus.deadtime_in;

  always_comb begin
    pwm_high_d = bus.enable && raw;
    pwm_low_d  = bus.enable && !raw;
  end
`endif

  always_ff @(posedge clockIn or posedge reset) begin
    if (reset) begin
      cmp_low_q   <= '0;
      cmp_high_q  <= '0;
      load_pend_q <= 1'b0;
      load_done_q <= 1'b0;
      pwm_high_q  <= 1'b0;
      pwm_low_q   <= 1'b0;
    end else begin
      cmp_low_q   <= cmp_low_d;
      cmp_high_q  <= cmp_high_d;
      load_pend_q <= load_pend_d;
      load_done_q <= load_done_d;
      pwm_high_q  <= pwm_high_d;
      pwm_low_q   <= pwm_low_d;
    end
  end

  assign bus.pwm_high  = pwm_high_q;
  assign bus.pwm_low   = pwm_low_q;
  assign bus.load_done = load_done_q;

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// Self-checking bench for pwm_compare_deadtime against a cycle-level behavioural model.
// Expectations follow the PWM_COMPARE_DEADTIME_EN build option.
module tb_pwm_compare_deadtime;
  import pwm_compare_pkg::*;

  localparam int CW = COUNTER_WIDTH_DEF;
  localparam int DW = DEADTIME_WIDTH_DEF;

  logic clock_in = 1'b0;
  logic reset;

  always #5 clock_in = ~clock_in;

  pwm_compare_deadtime_if #(.COUNTER_WIDTH(CW), .DEADTIME_WIDTH(DW)) bus ();

  pwm_compare_deadtime #(.COUNTER_WIDTH(CW), .DEADTIME_WIDTH(DW)) dut (
    .clockIn (clock_in),
    .reset   (reset),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Shadow values presented to the DUT
  int sh_lo, sh_hi, sh_dt;

  // Reference model: active window, pending load, driven side (0 off, 1 high, 2 low)
  int m_lo, m_hi, m_dt, m_side, m_dead;
  bit m_pend, m_high, m_low, m_done;

  // Observation counters for the current measurement window
  int n_high, n_low, n_dead, n_done, first_high, done_at;
  bit last_h, last_l;

  typedef struct {
    int lo;
    int hi;
    int dt;
    int exp_high;
    int exp_low;
    int exp_dead;
  } vec_t;

  vec_t vecs[5];

  function automatic void model_reset();
    m_lo = 0; m_hi = 0; m_dt = 0; m_side = 0; m_dead = 0;
    m_pend = 1'b0; m_high = 1'b0; m_low = 1'b0; m_done = 1'b0;
  endfunction

  function automatic void model_step(bit en, int cnt, bit strobe);
    bit raw, xfer;
    raw  = (cnt >= m_lo) && (cnt < m_hi);
    xfer = en && m_pend && (cnt == 0);
`ifdef PWM_COMPARE_DEADTIME_EN
    if (!en) begin
      m_side = 0;
      m_dead = 0;
    end else if (m_side == 0) begin
      m_side = raw ? 1 : 2;
    end else if (m_dead > 0) begin
      if (raw == (m_side == 1)) begin
        m_dead = 0;
      end else begin
        m_dead--;
        if (m_dead == 0) m_side = (m_side == 1) ? 2 : 1;
      end
    end else if (raw != (m_side == 1)) begin
      if (m_dt == 0) m_side = (m_side == 1) ? 2 : 1;
      else m_dead = m_dt;
    end
    m_high = (m_side == 1) && (m_dead == 0);
    m_low  = (m_side == 2) && (m_dead == 0);
`else
    m_high = en && raw;
    m_low  = en && !raw;
`endif
    m_done = xfer;
    if (xfer) begin
      m_lo = sh_lo; m_hi = sh_hi; m_dt = sh_dt;
    end
    m_pend = (m_pend && !xfer) || strobe;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic set_shadow(input int lo, input int hi, input int dt);
    sh_lo = lo; sh_hi = hi; sh_dt = dt;
    bus.compare_low_in  = CW'(lo);
    bus.compare_high_in = CW'(hi);
    bus.deadtime_in     = DW'(dt);
  endtask

  task automatic clear_counts();
    n_high = 0; n_low = 0; n_dead = 0; n_done = 0; first_high = -1; done_at = -1;
  endtask

  task automatic applyStimulus(input bit en, input int cnt, input bit strobe);
    int exp_v, act_v;
    bus.enable      = en;
    bus.count_in    = CW'(cnt);
    bus.load_strobe = strobe;
    @(posedge clock_in);
    model_step(en, cnt, strobe);
    #1;
    last_h = bus.pwm_high;
    last_l = bus.pwm_low;
    act_v  = int'(bus.pwm_high) * 4 + int'(bus.pwm_low) * 2 + int'(bus.load_done);
    exp_v  = int'(m_high) * 4 + int'(m_low) * 2 + int'(m_done);
    checkOutput($sformatf("outputs_hld@cnt%0d", cnt), act_v, exp_v);
    checkOutput("no_overlap", int'(bus.pwm_high & bus.pwm_low), 0);
    if (bus.pwm_high) begin
      n_high++;
      if (first_high < 0) first_high = cnt;
    end
    if (bus.pwm_low) n_low++;
    if (!bus.pwm_high && !bus.pwm_low) n_dead++;
    if (bus.load_done) begin
      n_done++;
      done_at = cnt;
    end
  endtask

  task automatic run_ramp(input int first, input int last, input int strobe_at);
    for (int c = first; c <= last; c++) applyStimulus(1'b1, c, c == strobe_at);
  endtask

  initial begin
`ifdef PWM_COMPARE_DEADTIME_EN
    vecs[0] = '{10, 20, 3, 7, 19, 6};
    vecs[1] = '{10, 20, 0, 10, 22, 0};
    vecs[2] = '{5, 25, 2, 18, 10, 4};
    vecs[3] = '{20, 10, 3, 0, 32, 0};
    vecs[4] = '{0, 8, 1, 7, 23, 2};
`else
    vecs[0] = '{10, 20, 3, 10, 22, 0};
    vecs[1] = '{10, 20, 0, 10, 22, 0};
    vecs[2] = '{5, 25, 2, 20, 12, 0};
    vecs[3] = '{20, 10, 3, 0, 32, 0};
    vecs[4] = '{0, 8, 1, 8, 24, 0};
`endif

    reset = 1'b1;
    bus.enable = 1'b0;
    bus.count_in = '0;
    bus.load_strobe = 1'b0;
    set_shadow(0, 0, 0);
    model_reset();
    clear_counts();
    repeat (2) @(posedge clock_in);
    #1;
    checkOutput("reset_outputs",
                int'(bus.pwm_high) * 4 + int'(bus.pwm_low) * 2 + int'(bus.load_done), 0);
    reset = 1'b0;

    // Steady-state duty and deadtime per threshold set, measured over one full ramp
    for (int v = 0; v < 5; v++) begin
      set_shadow(vecs[v].lo, vecs[v].hi, vecs[v].dt);
      run_ramp(16, 31, 16);
      run_ramp(0, 31, -1);
      clear_counts();
      run_ramp(0, 31, -1);
      checkOutput($sformatf("vec%0d_high_cycles", v), n_high, vecs[v].exp_high);
      checkOutput($sformatf("vec%0d_low_cycles", v), n_low, vecs[v].exp_low);
      checkOutput($sformatf("vec%0d_dead_cycles", v), n_dead, vecs[v].exp_dead);
    end

    // Mid-period reload: old window holds until wrap, then one load_done and new window
    set_shadow(10, 20, 3);
    run_ramp(0, 31, 5);
    run_ramp(0, 31, -1);
    run_ramp(0, 14, -1);
    set_shadow(5, 20, 3);
    clear_counts();
    run_ramp(15, 31, 15);
    checkOutput("old_window_held", n_high, 5);
    checkOutput("no_early_load", n_done, 0);
    clear_counts();
    run_ramp(0, 31, -1);
    checkOutput("load_done_pulses", n_done, 1);
    checkOutput("load_done_at_zero", done_at, 0);
`ifdef PWM_COMPARE_DEADTIME_EN
    checkOutput("new_window_rise", first_high, 8);
`else
    checkOutput("new_window_rise", first_high, 5);
`endif

    // Two-cycle raw glitch while high with deadtime 5
    set_shadow(10, 20, 5);
    run_ramp(0, 31, 3);
    run_ramp(0, 31, -1);
    run_ramp(0, 17, -1);
    clear_counts();
    applyStimulus(1'b1, 25, 1'b0);
    applyStimulus(1'b1, 25, 1'b0);
    applyStimulus(1'b1, 18, 1'b0);
`ifdef PWM_COMPARE_DEADTIME_EN
    checkOutput("glitch_low_never", n_low, 0);
    checkOutput("glitch_back_high", int'(last_h), 1);
`endif
    run_ramp(19, 31, -1);

    // Asynchronous reset while high side is on
    run_ramp(0, 17, -1);
    checkOutput("high_before_reset", int'(last_h), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_high", int'(bus.pwm_high), 0);
    checkOutput("async_reset_low", int'(bus.pwm_low), 0);
    @(posedge clock_in);
    #1 reset = 1'b0;
    model_reset();

    // Enable dropped during a low-to-high deadtime with a load pending
    set_shadow(10, 20, 3);
    run_ramp(0, 31, 1);
    run_ramp(0, 31, -1);
    set_shadow(4, 12, 2);
    run_ramp(0, 10, 2);
    clear_counts();
    applyStimulus(1'b0, 11, 1'b0);
    checkOutput("disable_outputs", int'(last_h) + int'(last_l), 0);
    for (int c = 12; c <= 35; c++) applyStimulus(1'b0, c % 32, 1'b0);
    checkOutput("no_load_while_disabled", n_done, 0);
    run_ramp(4, 31, -1);
    clear_counts();
    run_ramp(0, 31, -1);
    checkOutput("load_after_reenable", n_done, 1);
`ifdef PWM_COMPARE_DEADTIME_EN
    checkOutput("reenable_window_rise", first_high, 6);
`else
    checkOutput("reenable_window_rise", first_high, 4);
`endif

    // Randomised traffic: mostly ramping count, occasional jumps, strobes and disables
    begin
      int cnt;
      bit en, strobe;
      cnt = 0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 19) == 0) cnt = $urandom_range(0, 40);
        else cnt = (cnt + 1) % 32;
        en = ($urandom_range(0, 24) != 0);
        strobe = ($urandom_range(0, 19) == 0);
        if (strobe) set_shadow($urandom_range(0, 35), $urandom_range(0, 35), $urandom_range(0, 4));
        applyStimulus(en, cnt, strobe);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_compare_deadtime.md
PWM_COMPARE_DEADTIME -- requirements
Module: pwm_compare_deadtime

Interface
REQ-001 Parameter COUNTER_WIDTH, default 16, SHALL set the width of the count and compare values.
REQ-002 Parameter DEADTIME_WIDTH, default 8, SHALL set the width of the deadtime value.
REQ-003 clockIn  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 enable  in  1  SHALL gate the stage; low forces both outputs low and the FSM to IDLE.
REQ-006 count_in  in  COUNTER_WIDTH  SHALL be the running count from the upstream counter.
REQ-007 load_strobe  in  1  SHALL request a shadow-to-active transfer at the next count_in==0 cycle.
REQ-008 compare_low_in  in  COUNTER_WIDTH  SHALL be the shadow on-threshold.
REQ-009 compare_high_in  in  COUNTER_WIDTH  SHALL be the shadow off-threshold.
REQ-010 deadtime_in  in  DEADTIME_WIDTH  SHALL be the shadow deadtime, in clockIn cycles.
REQ-011 pwm_high  out  1  SHALL be the high-side gate drive.
REQ-012 pwm_low  out  1  SHALL be the low-side gate drive.
REQ-013 load_done  out  1  SHALL pulse for one cycle when the active registers are updated.

Function
REQ-014 Active compare/deadtime registers SHALL load from the shadows in the cycle where count_in==0 and a load request is pending; the request is latched on load_strobe and cleared on transfer.
REQ-015 The raw signal SHALL be 1 when compare_low <= count_in < compare_high, using unsigned compare; compare_low >= compare_high gives raw=0 always.
REQ-016 Outputs SHALL be registered with 1-cycle latency from count_in to raw.
REQ-017 FSM states SHALL be IDLE, HIGH_ON, DT_HL, LOW_ON and DT_LH.
REQ-018 IDLE SHALL be left on the first enabled cycle: to HIGH_ON if raw=1, else to LOW_ON.
REQ-019 Transitions SHALL be: HIGH_ON->DT_HL on raw falling; LOW_ON->DT_LH on raw rising.
REQ-020 Deadtime states SHALL load the deadtime counter with the active deadtime and decrement every clockIn cycle; leave at zero (DT_HL->LOW_ON, DT_LH->HIGH_ON).
REQ-021 If raw reverts during a deadtime state, the FSM SHALL return to the prior on-state next cycle.
REQ-022 Active deadtime==0 SHALL bypass the deadtime states; the direct transition must never assert both outputs in the same cycle.
REQ-023 pwm_high SHALL be 1 only in HIGH_ON; pwm_low SHALL be 1 only in LOW_ON; both SHALL never be 1 simultaneously.
REQ-024 A deassertion of enable mid-operation SHALL force both outputs to 0 on the next edge; the pending load request SHALL be retained.

Reset
REQ-025 On reset: state=IDLE, pwm_high=0, pwm_low=0, load_done=0, active registers=0, deadtime counter=0, load request cleared.

Configuration
REQ-026 With PWM_COMPARE_DEADTIME_EN defined, deadtime insertion (REQ-020..022) SHALL be compiled in.
REQ-027 Without PWM_COMPARE_DEADTIME_EN, pwm_high SHALL be registered raw and pwm_low SHALL be registered ~raw (both 0 when disabled); deadtime_in SHALL be ignored; the deadtime states SHALL be absent.

Structure
REQ-028 Package pwm_compare_pkg SHALL hold the FSM state enum typedef and the default width constants.
REQ-029 The deadtime down-counter SHALL be a sub-module named deadtime_counter, with ports load, value and zero.

Verification
REQ-030 compare_low=10, compare_high=20, deadtime=3, count ramps 0..31 -> pwm_high=1 for count 10..19 less 3 cycles at the rising edge; exactly 3 cycles with both outputs low at each edge.
REQ-031 load_strobe at count=15 with new compare_low=5 -> thresholds unchanged until count_in==0; load_done pulses once there; new window starts at 5.
REQ-032 deadtime=5 with a raw glitch of 2 cycles -> FSM returns to the prior on-state; the opposite output never asserts.
REQ-033 deadtime=0 -> no cycle has both outputs at 1; the complementary switch occurs within 1 cycle.
REQ-034 Reset asserted asynchronously mid-HIGH_ON -> pwm_high=0 immediately, without waiting for a clock edge; state=IDLE.
REQ-035 enable dropped during DT_LH with a load pending -> outputs 0 next cycle; the load is applied at the first count_in==0 after re-enable.
